// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//
// Purpose:
//   Shared definitions for the bit-serial subtractor slice. This holds the
//   controller state set, its legacy-compatible 2-bit constants, and the
//   default operand width.
//
// Contents:
//   state_e   - symbolic controller states (IDLE, RUN, DONE)
//   ST_IDLE   - 2-bit constant for IDLE
//   ST_RUN    - 2-bit constant for RUN
//   ST_DONE   - 2-bit constant for DONE
//   SUB_W     - default operand/result width (8)
//   sub_ref   - helper returning (x - y) mod 2^SUB_W together with the borrow
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  // Symbolic controller states. The encoding is fixed because older blocks
  // decode the raw 2-bit value directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Plain-vector versions of the states. The controller stores its state
  // in a logic vector, which keeps it compatible with legacy decoders.
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  // Default operand and result width of the arithmetic library subtractor.
  localparam int SUB_W = 8;

  // Word-level reference for a SUB_W-bit unsigned subtraction. Bit SUB_W of
  // the return value is the borrow-out, and the low bits are the difference.
  function automatic logic [SUB_W:0] sub_ref(input logic [SUB_W-1:0] x,
                                             input logic [SUB_W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//
// Purpose:
//   Bundles the start/done handshake and operand/result bus of the
//   bit-serial subtractor. The clock and reset stay as plain ports on the
//   modules.
//
// Parameters:
//   W       - operand and result width in bits (W >= 2)
//
// Signals:
//   start   - request, sampled by the subtractor only while idle
//   a       - minuend, captured on the accepted start edge
//   b       - subtrahend, captured on the accepted start edge
//   busy    - high while an operation is in flight (RUN or DONE)
//   done    - one-cycle pulse when diff/borrow hold a fresh result
//   diff    - registered result, (a - b) mod 2^W
//   borrow  - registered final borrow-out, 1 iff a < b (unsigned)
//
// Modports:
//   master  - requester side (drives start/a/b)
//   slave   - subtractor side (drives busy/done/diff/borrow)
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int W = serial_subtractor_pkg::SUB_W
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  borrow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output borrow
  );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// ---------------------------------------------------------------------------
// full_sub
//
// Purpose:
//   A combinational 1-bit full subtractor cell. It is built from gate
//   primitives in the same way as the library's half/full adder cells.
//   The cell computes x - y - bin.
//
// Ports:
//   x     input   minuend bit
//   y     input   subtrahend bit
//   bin   input   borrow-in
//   d     output  difference bit, x ^ y ^ bin
//   bout  output  borrow-out, (~x & y) | (~(x ^ y) & bin)
// ---------------------------------------------------------------------------
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x_xor_y;
  logic x_n;
  logic xy_eq;
  logic gen_borrow;
  logic prop_borrow;

  // The difference bit is the three-way parity of the inputs.
  xor g_xy   (x_xor_y, x, y);
  xor g_d    (d, x_xor_y, bin);

  // A borrow is generated when x=0 and y=1. An incoming borrow passes
  // through when x and y are equal.
  not g_xn   (x_n, x);
  and g_gen  (gen_borrow, x_n, y);
  not g_eq   (xy_eq, x_xor_y);
  and g_prop (prop_borrow, xy_eq, bin);
  or  g_bout (bout, gen_borrow, prop_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   A bit-serial W-bit unsigned subtractor that computes diff = a - b,
//   least significant bit first, one bit per clock. The datapath uses a
//   single full_sub cell and a borrow flop. Two operand shift registers
//   feed the cell, and a result shift register collects the difference
//   bits. This block is the low-area alternative to a parallel
//   ripple-borrow subtractor.
//
// Timing:
//   The start request is accepted at edge E0. RUN then lasts W cycles, and
//   done is high in the single cycle after edge E0+W. One operation is
//   completed every W+2 cycles.
//
// Parameters:
//   W       - operand and result width in bits (W >= 2)
//
// Ports:
//   clk     input   rising-edge clock
//   rst     input   synchronous, active-high reset (wins over start)
//   bus     slave   handshake/operand/result bundle (see serial_subtractor_if)
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = SUB_W
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);

  // The counter only has to reach W-1, so $clog2(W) bits are enough and it
  // never wraps inside an operation. Clamp to one bit so the code stays legal.
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [1:0]    state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  sr;
  logic          br;
  logic [CW-1:0] cnt;
  logic [W-1:0]  diff_q;
  logic          borrow_q;

  logic          cell_d;
  logic          cell_bout;

  // The only arithmetic in the datapath. It always looks at the current LSBs
  // of the operand shift registers and at the running borrow.
  full_sub u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Controller and datapath registers.
  //
  // IDLE loads fresh operands on start. RUN retires one bit per cycle. On
  // the W-th RUN cycle the completed word, including the bit being produced
  // at that edge, goes straight into the output register. Because of this,
  // diff and borrow only move on the edge that enters DONE. A partial result
  // therefore never shows, and reset clears everything, including the
  // outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          sa  <= {1'b0, sa[W-1:1]};
          sb  <= {1'b0, sb[W-1:1]};
          sr  <= {cell_d, sr[W-1:1]};
          br  <= cell_bout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff_q   <= {cell_d, sr[W-1:1]};
            borrow_q <= cell_bout;
            state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded directly from the state register. This
  // keeps done free of glitches and guarantees it is low in IDLE and RUN.
  // start is ignored while busy, so the request side needs no queue.
  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule
